// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// byte-enable constants and the read-lane selector.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'h1;

  function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] sel;
    case (lane)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      default: sel = word[31:24];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication on the way
// out, load lane selection and sign/zero extension on the way back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        st_bitype,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic        ld_bitype,
  input  logic        ld_unsign,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  always_comb begin
    st_be   = BE_WORD;
    st_data = st_wdata;
    if (st_bitype) begin
      st_be   = BE_BYTE0 << st_offset;
      st_data = {4{st_wdata[7:0]}};
    end
  end

  always_comb begin
    ld_byte = lane_select(ld_rdata, ld_offset);
    ld_data = ld_rdata;
    if (ld_bitype) begin
      ld_data = ld_unsign ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side data-memory initiator: captures one load/store from EX/MEM,
// runs it over the request/response bus and stalls the pipeline until done.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic                      ex_memread,
  input  logic                      ex_memwrite,
  input  logic                      ex_bitype,
  input  logic                      ex_unsign,
  input  logic [31:0]               ex_addr,
  input  logic [31:0]               ex_wdata,
  input  logic [4:0]                ex_rd,
  output logic                      stall,
  load_store_unit_if.master         mem,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      misalign_err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic        bitype_q;
  logic        unsign_q;
  logic [1:0]  offset_q;
  logic        misalign_q;
  logic [31:0] wb_data_q;

  logic        access;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign access     = ex_valid & (ex_memread | ex_memwrite);
  assign misaligned = ~ex_bitype & (ex_addr[1:0] != 2'b00);

  lsu_lane_align u_lane_align (
    .st_bitype (ex_bitype),
    .st_offset (ex_addr[1:0]),
    .st_wdata  (ex_wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_bitype (bitype_q),
    .ld_unsign (unsign_q),
    .ld_offset (offset_q),
    .ld_rdata  (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  // Everything the bus needs is captured in IDLE so it stays stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      we_q       <= 1'b0;
      rd_q       <= 5'h0;
      bitype_q   <= 1'b0;
      unsign_q   <= 1'b0;
      offset_q   <= 2'b00;
      misalign_q <= 1'b0;
      wb_data_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            addr_q     <= {ex_addr[31:2], 2'b00};
            wdata_q    <= st_data;
            be_q       <= st_be;
            we_q       <= ex_memwrite;
            rd_q       <= ex_rd;
            bitype_q   <= ex_bitype;
            unsign_q   <= ex_unsign;
            offset_q   <= ex_addr[1:0];
            misalign_q <= misaligned;
            state      <= misaligned ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            state <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            wb_data_q <= ld_data;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request valid is decoded from state so an async reset drops it at once.
  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign stall        = access & (state != S_DONE);
  assign wb_valid     = (state == S_DONE) & ~we_q & ~misalign_q;
  assign misalign_err = (state == S_DONE) & misalign_q;
  assign wb_rd        = rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed bus and writeback values
// for byte/word stores and loads, wait states, misalignment and reset.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_bitype;
  logic        ex_unsign;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  int checks;
  int errors;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_bitype    (ex_bitype),
    .ex_unsign    (ex_unsign),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .mem          (bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ex(input logic rd_en, input logic wr_en, input logic bt, input logic us,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_memread  = rd_en;
    ex_memwrite = wr_en;
    ex_bitype   = bt;
    ex_unsign   = us;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_rd       = rd;
  endtask

  task automatic idle_ex();
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
    ex_bitype   = 1'b0;
    ex_unsign   = 1'b0;
    ex_addr     = 32'h0;
    ex_wdata    = 32'h0;
    ex_rd       = 5'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_ex();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_output("rst_mem_req",   bus.mem_req,   0);
    check_output("rst_mem_we",    bus.mem_we,    0);
    check_output("rst_mem_addr",  bus.mem_addr,  0);
    check_output("rst_mem_be",    bus.mem_be,    0);
    check_output("rst_mem_wdata", bus.mem_wdata, 0);
    check_output("rst_wb_valid",  wb_valid,      0);
    check_output("rst_wb_data",   wb_data,       0);
    check_output("rst_wb_rd",     wb_rd,         0);
    check_output("rst_misalign",  misalign_err,  0);
    check_output("rst_stall",     stall,         0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // SB 0x13 <- 0xA5, zero wait states
    drive_ex(0, 1, 1, 0, 32'h13, 32'hA5, 5'd0);
    bus.mem_ready = 1'b1;
    settle();
    check_output("sb_c0_stall", stall, 1);
    check_output("sb_c0_req",   bus.mem_req, 0);
    tick();
    check_output("sb_c1_req",   bus.mem_req,   1);
    check_output("sb_c1_we",    bus.mem_we,    1);
    check_output("sb_c1_addr",  bus.mem_addr,  32'h10);
    check_output("sb_c1_be",    bus.mem_be,    4'b1000);
    check_output("sb_c1_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    check_output("sb_c1_stall", stall, 1);
    tick();
    check_output("sb_c2_stall", stall, 0);
    check_output("sb_c2_req",   bus.mem_req, 0);
    check_output("sb_c2_wbv",   wb_valid, 0);
    idle_ex();
    bus.mem_ready = 1'b0;
    tick();

    // SW 0x44 <- 0x11223344, one REQ wait state
    drive_ex(0, 1, 0, 0, 32'h44, 32'h11223344, 5'd0);
    tick();
    check_output("sw_c1_req",   bus.mem_req,   1);
    check_output("sw_c1_addr",  bus.mem_addr,  32'h44);
    check_output("sw_c1_be",    bus.mem_be,    4'hF);
    check_output("sw_c1_wdata", bus.mem_wdata, 32'h11223344);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check_output("sw_c2_req",   bus.mem_req, 1);
    check_output("sw_c2_stall", stall, 1);
    tick();
    check_output("sw_c3_stall", stall, 0);
    idle_ex();
    bus.mem_ready = 1'b0;
    tick();

    // LB 0x21 -> x7, two wait states in REQ and in WAIT
    drive_ex(1, 0, 1, 0, 32'h21, 32'h0, 5'd7);
    settle();
    check_output("lb_c0_stall", stall, 1);
    check_output("lb_c0_wbv",   wb_valid, 0);
    tick();
    check_output("lb_c1_req",   bus.mem_req,  1);
    check_output("lb_c1_we",    bus.mem_we,   0);
    check_output("lb_c1_addr",  bus.mem_addr, 32'h20);
    check_output("lb_c1_be",    bus.mem_be,   4'b0010);
    check_output("lb_c1_wbv",   wb_valid, 0);
    tick();
    check_output("lb_c2_req",   bus.mem_req,  1);
    check_output("lb_c2_addr",  bus.mem_addr, 32'h20);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check_output("lb_c3_req",   bus.mem_req, 1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check_output("lb_c4_req",   bus.mem_req, 0);
    check_output("lb_c4_stall", stall, 1);
    check_output("lb_c4_wbv",   wb_valid, 0);
    tick();
    check_output("lb_c5_wbv",   wb_valid, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000F000;
    settle();
    check_output("lb_c6_wbv",   wb_valid, 0);
    check_output("lb_c6_stall", stall, 1);
    tick();
    check_output("lb_c7_wbv",   wb_valid, 1);
    check_output("lb_c7_data",  wb_data,  32'hFFFFFFF0);
    check_output("lb_c7_rd",    wb_rd,    5'd7);
    check_output("lb_c7_stall", stall, 0);
    bus.mem_rvalid = 1'b0;
    idle_ex();
    tick();
    check_output("lb_c8_wbv",   wb_valid, 0);

    // LBU 0x21 -> x7, zero wait states
    drive_ex(1, 0, 1, 1, 32'h21, 32'h0, 5'd7);
    bus.mem_ready = 1'b1;
    tick();
    check_output("lbu_c1_req", bus.mem_req, 1);
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000F000;
    tick();
    check_output("lbu_c3_wbv",  wb_valid, 1);
    check_output("lbu_c3_data", wb_data,  32'h000000F0);
    bus.mem_rvalid = 1'b0;
    idle_ex();
    tick();

    // LW 0x06: misaligned, no bus request
    drive_ex(1, 0, 0, 0, 32'h06, 32'h0, 5'd4);
    settle();
    check_output("mis_c0_stall", stall, 1);
    check_output("mis_c0_req",   bus.mem_req, 0);
    tick();
    check_output("mis_c1_err",   misalign_err, 1);
    check_output("mis_c1_req",   bus.mem_req, 0);
    check_output("mis_c1_wbv",   wb_valid, 0);
    check_output("mis_c1_stall", stall, 0);
    idle_ex();
    tick();
    check_output("mis_c2_err",   misalign_err, 0);
    check_output("mis_c2_req",   bus.mem_req, 0);

    // Spurious rvalid in IDLE, in REQ and on the accepting cycle
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick();
    check_output("spur_idle_wbv", wb_valid, 0);
    check_output("spur_idle_req", bus.mem_req, 0);
    drive_ex(1, 0, 0, 0, 32'h08, 32'h0, 5'd2);
    tick();
    check_output("spur_c1_req", bus.mem_req, 1);
    check_output("spur_c1_wbv", wb_valid, 0);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check_output("spur_c2_req", bus.mem_req, 1);
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    settle();
    check_output("spur_c3_req",   bus.mem_req, 0);
    check_output("spur_c3_wbv",   wb_valid, 0);
    check_output("spur_c3_stall", stall, 1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    settle();
    check_output("spur_c4_wbv", wb_valid, 0);
    tick();
    check_output("spur_c5_wbv",  wb_valid, 1);
    check_output("spur_c5_data", wb_data,  32'hCAFEF00D);
    check_output("spur_c5_rd",   wb_rd,    5'd2);
    bus.mem_rvalid = 1'b0;
    idle_ex();
    tick();

    // Reset while in WAIT, then a clean LW
    drive_ex(1, 0, 0, 0, 32'h40, 32'h0, 5'd3);
    bus.mem_ready = 1'b1;
    tick();
    check_output("rw_c1_req", bus.mem_req, 1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check_output("rw_c2_req", bus.mem_req, 0);
    rst = 1'b1;
    settle();
    check_output("rw_rst_req",  bus.mem_req,  0);
    check_output("rw_rst_rd",   wb_rd,        0);
    check_output("rw_rst_data", wb_data,      0);
    check_output("rw_rst_addr", bus.mem_addr, 0);
    idle_ex();
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    tick();
    check_output("rw_late_wbv",  wb_valid, 0);
    check_output("rw_late_data", wb_data,  0);
    bus.mem_rvalid = 1'b0;
    drive_ex(1, 0, 0, 0, 32'h40, 32'h0, 5'd9);
    bus.mem_ready = 1'b1;
    settle();
    check_output("lw_c0_req",   bus.mem_req, 0);
    check_output("lw_c0_stall", stall, 1);
    tick();
    check_output("lw_c1_req",  bus.mem_req,  1);
    check_output("lw_c1_addr", bus.mem_addr, 32'h40);
    check_output("lw_c1_be",   bus.mem_be,   4'hF);
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    tick();
    check_output("lw_c3_wbv",  wb_valid, 1);
    check_output("lw_c3_data", wb_data,  32'h12345678);
    check_output("lw_c3_rd",   wb_rd,    5'd9);
    bus.mem_rvalid = 1'b0;
    idle_ex();
    tick();
    check_output("lw_c4_wbv", wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
